mem_exec_unit: RTL and testbench

Execute stage placed directly downstream of the instruction fetch/decode CPU block. It accepts a decoded instruction (opcode, 6-bit dest and src RAM addresses) and a start pulse. It then reads its operands from the 64×16 data RAM, computes the result in an internal 16-bit ALU, and writes the result back to `dest`. It reports `busy`/`done` so the sequencer can advance the program counter only after writeback completes.

---
 rtl/mem_exec_pkg.sv | 39 +++
 rtl/mem_exec_alu.sv | 50 +++++
 rtl/mem_exec_unit.sv | 154 +++++++++++++++
 tb/tb_mem_exec_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_exec_pkg.sv
// Shared definitions for the memory-operand execute stage:
// opcode encodings, FSM state type, opcode classification helpers
// and default word/address widths.
package mem_exec_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 6;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SRC,
        ST_RD_DST,
        ST_CALC,
        ST_WB,
        ST_DONE
    } state_e;

    // Binary ops need both dest and src read from RAM.
    function automatic logic is_binary(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    // Opcodes A-F are undefined.
    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SHR;
    endfunction

endpackage

// File: rtl/mem_exec_alu.sv
// Combinational ALU for the execute stage. Operand A is the dest word
// for binary ops and the src word for unary ops; operand B is the src
// word (binary ops only).
module mem_exec_alu
    import mem_exec_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [3:0]    op_i,
    output logic [DW-1:0] result_o,
    output logic          carry_o
);

    logic [DW:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    // Result and carry/borrow for every opcode; NOP/illegal give zeros.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_MOV: result_o = a_i;
            OP_ADD: begin
                result_o = sum[DW-1:0];
                carry_o  = sum[DW];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_SHL: begin
                result_o = {a_i[DW-2:0], 1'b0};
                carry_o  = a_i[DW-1];
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[DW-1:1]};
                carry_o  = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_exec_unit.sv
// Execute stage: reads operands from the external data RAM, runs them
// through the ALU and writes the result back to dest.
// Optional macro MEM_EXEC_FLAGS_EN adds registered zero/carry flags;
// without it flag_z/flag_c are tied low.
module mem_exec_unit
    import mem_exec_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    opcode,
    input  logic [AW-1:0] dest,
    input  logic [AW-1:0] src,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_read,
    output logic          ram_write,
    output logic [DW-1:0] ram_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          flag_z,
    output logic          flag_c
);

    state_e        state_q, state_d;
    logic [3:0]    op_q;
    logic [AW-1:0] dest_q;
    logic [AW-1:0] src_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] result_q;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    // Operand A comes straight off the RAM read port during CALC.
    mem_exec_alu #(.DW(DW)) u_alu (
        .a_i      (ram_rdata),
        .b_i      (opb_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // State register, instruction latch, operand B and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            dest_q   <= '0;
            src_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                op_q   <= opcode;
                dest_q <= dest;
                src_q  <= src;
            end
            if (state_q == ST_RD_DST) begin
                opb_q <= ram_rdata;
            end
            if (state_q == ST_CALC) begin
                result_q <= alu_result;
            end
        end
    end

    // Next-state sequencing; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!is_legal(opcode) || opcode == OP_NOP) state_d = ST_DONE;
                    else                                       state_d = ST_RD_SRC;
                end
            end
            ST_RD_SRC: state_d = is_binary(op_q) ? ST_RD_DST : ST_CALC;
            ST_RD_DST: state_d = ST_CALC;
            ST_CALC:   state_d = ST_WB;
            ST_WB:     state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // RAM drive and status outputs decoded from the current state.
    always_comb begin
        ram_addr  = '0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_RD_SRC: begin
                ram_read = 1'b1;
                ram_addr = src_q;
            end
            ST_RD_DST: begin
                ram_read = 1'b1;
                ram_addr = dest_q;
            end
            ST_WB: begin
                ram_write = 1'b1;
                ram_addr  = dest_q;
                ram_wdata = result_q;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = !is_legal(op_q);
            end
            default: ;
        endcase
    end

`ifdef MEM_EXEC_FLAGS_EN
    logic carry_q;
    logic flag_z_q;
    logic flag_c_q;

    // Carry is held from CALC; both flags commit as WB completes, so
    // an operation aborted by reset never disturbs them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (state_q == ST_CALC) begin
                carry_q <= alu_carry;
            end
            if (state_q == ST_WB) begin
                flag_z_q <= (result_q == '0);
                flag_c_q <= carry_q;
            end
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic unused_alu_carry;
    assign unused_alu_carry = alu_carry;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_mem_exec_unit.sv
// Scoreboard bench for mem_exec_unit: the driver pushes the expected
// outcome of each instruction, a monitor compares on every done pulse.
module tb_mem_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic [5:0]  dest;
    logic [5:0]  src;
    logic [15:0] ram_rdata;
    logic [5:0]  ram_addr;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_c;

    mem_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .dest      (dest),
        .src       (src),
        .ram_rdata (ram_rdata),
        .ram_addr  (ram_addr),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    always #5 clk = ~clk;

    // Data RAM model: one-cycle registered read, synchronous write.
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (ram_read)  ram_rdata <= mem[ram_addr];
        if (ram_write) mem[ram_addr] <= ram_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  op;
        bit          wr;
        logic [5:0]  waddr;
        logic [15:0] wdata;
        bit          err;
        bit          z;
        bit          c;
        int          lat;
        int          nrd;
        int          scyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   model_z = 1'b0;
    bit   model_c = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: tallies strobes per transaction, checks on done.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    int          wr_cyc;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (ram_read) rd_cnt++;
            if (ram_write) begin
                if (sb.size() == 0) chk("unexpected_write", 1, 0);
                wr_cnt++;
                wr_addr = ram_addr;
                wr_data = ram_wdata;
                wr_cyc  = cyc;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - e.scyc, e.lat);
                    chk("err", err, e.err);
                    chk("flag_z", flag_z, e.z);
                    chk("flag_c", flag_c, e.c);
                    chk("read_count", rd_cnt, e.nrd);
                    chk("write_count", wr_cnt, e.wr ? 1 : 0);
                    if (e.wr && wr_cnt == 1) begin
                        chk("write_addr", wr_addr, e.waddr);
                        chk("write_data", wr_data, e.wdata);
                        chk("write_cycle", wr_cyc, cyc - 1);
                    end
                    $display("txn op=%h lat=%0d err=%0b z=%0b c=%0b wr=%0d data=%h",
                             e.op, cyc - e.scyc, err, flag_z, flag_c, wr_cnt, wr_data);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Issue one instruction, push its expectation, wait for completion.
    task automatic run_op(input logic [3:0] opc, input logic [5:0] d, input logic [5:0] s,
                          input logic [15:0] wdata, input bit ez, input bit ec, input bit mid);
        exp_t e;
        bit legal, writes, bin;
        legal  = (opc <= 4'h9);
        writes = legal && (opc != 4'h0);
        bin    = (opc >= 4'h2) && (opc <= 4'h6);
        if (writes) begin
            model_z = ez;
            model_c = ec;
        end
        e.op    = opc;
        e.wr    = writes;
        e.waddr = d;
        e.wdata = wdata;
        e.err   = !legal;
`ifdef MEM_EXEC_FLAGS_EN
        e.z     = model_z;
        e.c     = model_c;
`else
        e.z     = 1'b0;
        e.c     = 1'b0;
`endif
        e.lat   = writes ? (bin ? 5 : 4) : 1;
        e.nrd   = writes ? (bin ? 2 : 1) : 0;
        @(posedge clk); #1;
        start = 1'b1; opcode = opc; dest = d; src = s;
        e.scyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; opcode = 4'hA; dest = 6'h3F; src = 6'h3F;
        if (mid) begin
            @(posedge clk); #1;
            start = 1'b1; opcode = 4'h0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_read"},  ram_read, 0);
        chk({tag, "_write"}, ram_write, 0);
        chk({tag, "_addr"},  ram_addr, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
        chk({tag, "_flags"}, {flag_z, flag_c}, 0);
    endtask

    initial begin
        logic [15:0] saved;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[1] = 16'h0001; mem[2] = 16'h0002; mem[3] = 16'h0005; mem[4] = 16'h0007;
        mem[5] = 16'h1234; mem[9] = 16'h8001; mem[30] = 16'hFFFF; mem[31] = 16'h0001;
        reset = 1'b0; start = 1'b0; opcode = 4'h0; dest = 6'h0; src = 6'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        // opcode  dest src  wdata    z  c  extra start while busy
        run_op(4'h2, 3,  4,  16'h000C, 0, 0, 1);   // ADD
        run_op(4'h3, 1,  2,  16'hFFFF, 0, 1, 0);   // SUB with borrow
        run_op(4'h8, 10, 9,  16'h0002, 0, 1, 0);   // SHL
        run_op(4'h6, 5,  5,  16'h0000, 1, 0, 0);   // XOR dest==src
        run_op(4'hF, 7,  8,  16'h0000, 0, 0, 0);   // illegal, flags held
        run_op(4'h0, 7,  8,  16'h0000, 0, 0, 0);   // NOP, flags held
        run_op(4'h2, 30, 31, 16'h0000, 1, 1, 0);   // ADD wrap
        run_op(4'h1, 20, 4,  16'h0007, 0, 0, 0);   // MOV
        run_op(4'h7, 21, 3,  16'hFFF3, 0, 0, 0);   // NOT
        run_op(4'h9, 22, 9,  16'h4000, 0, 1, 0);   // SHR
        run_op(4'h4, 3,  4,  16'h0004, 0, 0, 0);   // AND
        run_op(4'h5, 3,  4,  16'h0007, 0, 0, 0);   // OR

        chk("ram3", mem[3], 16'h0007);
        chk("ram1", mem[1], 16'hFFFF);
        chk("ram10", mem[10], 16'h0002);
        chk("ram5", mem[5], 16'h0000);

        // ADD aborted by reset asserted during CALC.
        saved = mem[3];
        @(posedge clk); #1;
        start = 1'b1; opcode = 4'h2; dest = 6'd3; src = 6'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        model_z = 1'b0;
        model_c = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_ram", mem[3], saved);

        run_op(4'h1, 24, 2, 16'h0002, 0, 0, 0);   // recovery after abort
        chk("ram24", mem[24], 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
